// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Registered program counter with next-PC select and a
//                circular return-address stack for BL/RET.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                    PC_WIDTH     = 64,
  parameter int                    IMM_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4,
  parameter int                    INSTR_SHIFT  = 2
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         Stall,
  input  logic                         Branch,
  input  logic                         BranchNZ,
  input  logic                         ALUZero,
  input  logic                         Uncondbranch,
  input  logic                         Link,
  input  logic                         BranchReg,
  input  logic                         Return,
  input  logic [PC_WIDTH-1:0]          RegTarget,
  input  logic [IMM_WIDTH-1:0]         SignExtImm,
  output logic [PC_WIDTH-1:0]          CurrentPC,
  output logic [PC_WIDTH-1:0]          NextPC,
  output logic                         Taken,
  output logic [$clog2(RAS_DEPTH):0]   RASCount,
  output logic                         RASOverflow,
  output logic                         RASUnderflow
);

  localparam int                      c_ptr_w = $clog2(RAS_DEPTH);
  localparam int                      c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]      c_full  = c_cnt_w'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0]     c_step  = PC_WIDTH'(1) << INSTR_SHIFT;

  logic [PC_WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [c_ptr_w-1:0]  r_wp;
  logic [c_ptr_w-1:0]  w_top_idx;
  logic [PC_WIDTH-1:0] w_off;
  logic [PC_WIDTH-1:0] w_seq;
  logic [PC_WIDTH-1:0] w_rel;
  logic [PC_WIDTH-1:0] w_top;
  logic                w_empty;
  logic                w_full;
  logic                w_push;

  generate
    if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
      assign w_off = SignExtImm[PC_WIDTH-1:0];
    end else begin : g_imm_sext
      assign w_off = {{(PC_WIDTH-IMM_WIDTH){SignExtImm[IMM_WIDTH-1]}}, SignExtImm};
    end
  endgenerate

  assign w_seq     = CurrentPC + c_step;
  assign w_rel     = CurrentPC + (w_off << INSTR_SHIFT);
  // r_wp points at the next free slot, so the top of stack sits just below it
  assign w_top_idx = r_wp - c_ptr_w'(1);
  assign w_top     = r_stack[w_top_idx];
  assign w_empty   = (RASCount == '0);
  assign w_full    = (RASCount == c_full);
  assign w_push    = Uncondbranch & Link & ~Return & ~Stall;

  always_comb begin
    NextPC = w_seq;
    Taken  = 1'b0;
    if (Return) begin
      Taken  = 1'b1;
      NextPC = w_empty ? RegTarget : w_top;
    end else if (BranchReg) begin
      Taken  = 1'b1;
      NextPC = RegTarget;
    end else if (Uncondbranch) begin
      Taken  = 1'b1;
      NextPC = w_rel;
    end else if (Branch && (ALUZero ^ BranchNZ)) begin
      Taken  = 1'b1;
      NextPC = w_rel;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      CurrentPC    <= RESET_VECTOR;
      RASCount     <= '0;
      r_wp         <= '0;
      RASOverflow  <= 1'b0;
      RASUnderflow <= 1'b0;
    end else if (!Stall) begin
      CurrentPC <= NextPC;
      if (w_push) begin
        // When full the write slot holds the oldest entry, so it is overwritten
        r_wp <= r_wp + c_ptr_w'(1);
        if (w_full) begin
          RASOverflow <= 1'b1;
        end else begin
          RASCount <= RASCount + c_cnt_w'(1);
        end
      end else if (Return) begin
        if (w_empty) begin
          RASUnderflow <= 1'b1;
        end else begin
          r_wp     <= w_top_idx;
          RASCount <= RASCount - c_cnt_w'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset && w_push) begin
      r_stack[r_wp] <= w_seq;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: queue-based reference model plus directed vectors.
`default_nettype none

module tb_pc_sequencer;

  localparam logic [63:0] RV    = 64'h1000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        Reset, Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, BranchReg, Return;
  logic [63:0] RegTarget, SignExtImm;
  logic [63:0] CurrentPC, NextPC;
  logic        Taken;
  logic [2:0]  RASCount;
  logic        RASOverflow, RASUnderflow;

  int errors = 0;
  int checks = 0;

  logic [63:0] m_pc;
  logic [63:0] m_ras[$];
  bit          m_ovf, m_unf, m_valid;

  pc_sequencer #(
    .PC_WIDTH(64), .IMM_WIDTH(64), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH), .INSTR_SHIFT(2)
  ) dut (
    .CLK(clk), .Reset(Reset), .Stall(Stall), .Branch(Branch), .BranchNZ(BranchNZ),
    .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .Link(Link), .BranchReg(BranchReg),
    .Return(Return), .RegTarget(RegTarget), .SignExtImm(SignExtImm),
    .CurrentPC(CurrentPC), .NextPC(NextPC), .Taken(Taken), .RASCount(RASCount),
    .RASOverflow(RASOverflow), .RASUnderflow(RASUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec priority: RET, BR, B/BL, conditional, sequential. Returns {taken, next}.
  function automatic logic [64:0] model_next();
    logic [63:0] rel;
    rel = m_pc + (SignExtImm << 2);
    if (Return)       return {1'b1, (m_ras.size() > 0) ? m_ras[$] : RegTarget};
    if (BranchReg)    return {1'b1, RegTarget};
    if (Uncondbranch) return {1'b1, rel};
    if (Branch && (ALUZero != BranchNZ)) return {1'b1, rel};
    return {1'b0, m_pc + 64'd4};
  endfunction

  task automatic model_update();
    logic [64:0] nx;
    if (Reset) begin
      m_pc = RV;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_valid = 1'b1;
    end else if (!Stall) begin
      nx = model_next();
      if (Return) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
      end else if (Uncondbranch && Link) begin
        m_ras.push_back(m_pc + 64'd4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      m_pc = nx[63:0];
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (m_valid) begin
      e = model_next();
      check("m_CurrentPC", CurrentPC, m_pc);
      check("m_NextPC", NextPC, e[63:0]);
      check("m_Taken", 64'(Taken), 64'(e[64]));
      check("m_RASCount", 64'(RASCount), 64'(m_ras.size()));
      check("m_RASOverflow", 64'(RASOverflow), 64'(m_ovf));
      check("m_RASUnderflow", 64'(RASUnderflow), 64'(m_unf));
    end
  end

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    Stall = 0; Branch = 0; BranchNZ = 0; ALUZero = 0; Uncondbranch = 0;
    Link = 0; BranchReg = 0; Return = 0; RegTarget = '0; SignExtImm = '0;
  endtask

  task automatic bl4();
    Uncondbranch = 1; Link = 1; SignExtImm = 64'd4;
  endtask

  initial begin
    logic [63:0] rets [4];
    rets[0] = 64'h248; rets[1] = 64'h238; rets[2] = 64'h228; rets[3] = 64'h218;
    m_valid = 1'b0;
    clr();
    Reset = 1;
    adv(); adv();
    Reset = 0;
    #1 check("rst_pc", CurrentPC, 64'h1000);
    check("rst_taken", 64'(Taken), 64'd0);
    check("rst_cnt", 64'(RASCount), 64'd0);
    adv(); #1 check("seq_1004", CurrentPC, 64'h1004);
    adv(); #1 check("seq_1008", CurrentPC, 64'h1008);
    adv(); #1 check("seq_100c", CurrentPC, 64'h100C);
    check("seq_next", NextPC, 64'h1010);

    BranchReg = 1; RegTarget = 64'h100;
    #1 check("br_100_next", NextPC, 64'h100);
    adv(); clr();
    Branch = 1; SignExtImm = 64'hFFFF_FFFF_FFFF_FFFE; ALUZero = 1; BranchNZ = 0;
    #1 check("cbz_next", NextPC, 64'hF8);
    check("cbz_taken", 64'(Taken), 64'd1);
    BranchNZ = 1;
    #1 check("cbnz_next", NextPC, 64'h104);
    check("cbnz_taken", 64'(Taken), 64'd0);
    adv(); clr();
    #1 check("cbnz_pc", CurrentPC, 64'h104);

    BranchReg = 1; RegTarget = 64'h200;
    adv(); clr();
    Uncondbranch = 1; SignExtImm = 64'd4;
    #1 check("b_next", NextPC, 64'h210);
    check("b_taken", 64'(Taken), 64'd1);
    Link = 1;
    adv(); clr();
    #1 check("bl_pc", CurrentPC, 64'h210);
    check("bl_cnt", 64'(RASCount), 64'd1);
    Return = 1;
    #1 check("ret_next", NextPC, 64'h204);
    adv(); clr();
    #1 check("ret_cnt", 64'(RASCount), 64'd0);
    check("ret_pc", CurrentPC, 64'h204);

    for (int i = 0; i < 5; i++) begin
      bl4();
      adv(); clr();
    end
    #1 check("ovf_cnt", 64'(RASCount), 64'd4);
    check("ovf_flag", 64'(RASOverflow), 64'd1);
    check("ovf_pc", CurrentPC, 64'h254);
    for (int i = 0; i < 4; i++) begin
      Return = 1; RegTarget = 64'hABC;
      #1 check("lifo_ret", NextPC, rets[i]);
      adv(); clr();
    end
    Return = 1; RegTarget = 64'hABC;
    #1 check("unf_next", NextPC, 64'hABC);
    adv(); clr();
    #1 check("unf_flag", 64'(RASUnderflow), 64'd1);
    check("unf_cnt", 64'(RASCount), 64'd0);
    check("unf_pc", CurrentPC, 64'hABC);

    Stall = 1; BranchReg = 1; RegTarget = 64'h300;
    #1 check("stall_next", NextPC, 64'h300);
    adv(); #1 check("stall_hold1", CurrentPC, 64'hABC);
    adv(); #1 check("stall_hold2", CurrentPC, 64'hABC);
    Stall = 0;
    adv(); clr();
    #1 check("stall_release", CurrentPC, 64'h300);

    bl4();
    adv(); clr();
    Return = 1; bl4();
    #1 check("ret_bl_next", NextPC, 64'h304);
    adv(); clr();
    #1 check("ret_bl_cnt", 64'(RASCount), 64'd0);
    check("ret_bl_pc", CurrentPC, 64'h304);
    Stall = 1; bl4();
    adv(); clr();
    #1 check("stall_bl_cnt", 64'(RASCount), 64'd0);

    BranchReg = 1; RegTarget = 64'hFFFF_FFFF_FFFF_FFFC;
    adv(); clr();
    #1 check("wrap_next", NextPC, 64'h0);
    adv(); #1 check("wrap_pc", CurrentPC, 64'h0);
    adv();
    bl4();
    adv(); clr();
    #1 check("pre_rst_cnt", 64'(RASCount), 64'd1);
    Reset = 1; Stall = 1; bl4();
    adv();
    #1 check("rst2_pc", CurrentPC, RV);
    check("rst2_cnt", 64'(RASCount), 64'd0);
    check("rst2_ovf", 64'(RASOverflow), 64'd0);
    check("rst2_unf", 64'(RASUnderflow), 64'd0);
    Reset = 0; clr();
    adv(); adv();
    #1 check("post_rst_pc", CurrentPC, RV + 64'd8);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
